// File: rtl/blake2_digest_serializer.sv
// Serializes a captured 512-bit Blake2 digest onto a processor bus, most significant word first.
// Optional macro DIGEST_TRUNCATE_EN adds out_len so only a prefix of the digest is sent.
module blake2_digest_serializer #(
  parameter int proc_bus_width = 32,
  parameter int digest_words   = 512 / proc_bus_width
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [511:0]              digest,
  input  logic                      digest_valid,
  input  logic                      new_hash_request,
`ifdef DIGEST_TRUNCATE_EN
  input  logic [$clog2(digest_words):0] out_len,
`endif
  output logic [proc_bus_width-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int idx_w = (digest_words > 1) ? $clog2(digest_words) : 1;
  localparam logic [idx_w-1:0] final_idx = idx_w'(digest_words - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state, state_nxt;
  logic [idx_w-1:0]          idx, idx_nxt;
  logic [idx_w-1:0]          last_idx, last_sel;
  logic                      dv_q;
  logic                      overrun_nxt;
  logic                      capture;
  logic                      rise;
  logic                      xfer;
  logic [511:0]              shadow;
  logic [proc_bus_width-1:0] word_arr [digest_words];

  assign rise = digest_valid & ~dv_q;
  assign xfer = out_valid & out_ready;

  for (genvar k = 0; k < digest_words; k++) begin : g_words
    assign word_arr[k] = shadow[511 - k*proc_bus_width -: proc_bus_width];
  end

`ifdef DIGEST_TRUNCATE_EN
  localparam int len_w = $clog2(digest_words) + 1;
  // Zero or oversize lengths fall back to the full digest.
  always_comb begin
    last_sel = final_idx;
    if (out_len != '0 && int'(out_len) <= digest_words)
      last_sel = idx_w'(out_len - len_w'(1));
  end
`else
  assign last_sel = final_idx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      dv_q     <= 1'b0;
      shadow   <= '0;
      overrun  <= 1'b0;
      last_idx <= final_idx;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      dv_q    <= digest_valid;
      overrun <= overrun_nxt;
      if (capture) begin
        shadow   <= digest;
        last_idx <= last_sel;
      end
    end
  end

  // new_hash_request dominates both capture and a coincident transfer.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    overrun_nxt = overrun;
    capture     = 1'b0;
    if (new_hash_request) begin
      state_nxt   = IDLE;
      idx_nxt     = '0;
      overrun_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = SEND;
            idx_nxt   = '0;
            capture   = 1'b1;
          end
        end
        SEND: begin
          if (rise) overrun_nxt = 1'b1;
          if (xfer) begin
            if (idx == last_idx) begin
              state_nxt = IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + idx_w'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == SEND);
    busy      = (state == SEND);
    out_last  = (state == SEND) && (idx == last_idx);
    out_data  = '0;
    if (state == SEND) out_data = word_arr[idx];
  end

endmodule

// File: tb/tb_blake2_digest_serializer.sv
// Directed bench for blake2_digest_serializer at 32-bit bus width.
// The truncation scenario is compiled in only when DIGEST_TRUNCATE_EN is defined.
module tb_blake2_digest_serializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] digest;
  logic         digest_valid;
  logic         new_hash_request;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overrun;
`ifdef DIGEST_TRUNCATE_EN
  logic [4:0]   out_len;
`endif

  int n_checks = 0;
  int n_errors = 0;

  blake2_digest_serializer #(.proc_bus_width(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .digest           (digest),
    .digest_valid     (digest_valid),
    .new_hash_request (new_hash_request),
`ifdef DIGEST_TRUNCATE_EN
    .out_len          (out_len),
`endif
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_exp(input int pat, input int k);
    logic [31:0] kk;
    kk = k;
    if (pat == 0) return kk;
    return 32'hC0DE_0000 ^ (kk * 32'h0101_0101);
  endfunction

  function automatic logic [511:0] make_digest(input int pat);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) d[511 - k*32 -: 32] = word_exp(pat, k);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the capture edge, i.e. word 0 on the bus.
  task automatic start_capture(input int pat);
    digest_valid = 1'b0;
    tick();
    digest       = make_digest(pat);
    digest_valid = 1'b1;
    tick();
  endtask

  task automatic pulse_new_hash();
    new_hash_request = 1'b1;
    tick();
    new_hash_request = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b0;
    digest           = '0;
    digest_valid     = 1'b0;
    new_hash_request = 1'b0;
    out_ready        = 1'b0;
`ifdef DIGEST_TRUNCATE_EN
    out_len          = '0;
`endif
    tick();
    tick();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_data", out_data, 0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_valid", out_valid, 0);

    // Full digest, ready held high
    out_ready = 1'b1;
    digest    = make_digest(0);
    digest_valid = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      check_eq("seq_valid", out_valid, 1);
      check_eq("seq_data", out_data, word_exp(0, k));
      check_eq("seq_last", out_last, (k == 15));
    end
    tick();
    check_eq("seq_end_valid", out_valid, 0);
    check_eq("seq_end_busy", busy, 0);
    check_eq("seq_end_data", out_data, 0);
    tick();
    tick();
    check_eq("no_retrigger", out_valid, 0);

    // Ready toggling 1,0,1,0: word index advances every other cycle
    start_capture(1);
    for (int c = 0; c <= 30; c++) begin
      check_eq("tog_valid", out_valid, 1);
      check_eq("tog_data", out_data, word_exp(1, (c + 1) / 2));
      check_eq("tog_last", out_last, ((c + 1) / 2 == 15));
      out_ready = (c % 2 == 0);
      tick();
    end
    check_eq("tog_end_valid", out_valid, 0);

    // Abort after word 5, then restart from word 0
    out_ready = 1'b1;
    start_capture(0);
    for (int c = 0; c < 6; c++) begin
      check_eq("abort_data", out_data, word_exp(0, c));
      tick();
    end
    check_eq("abort_word6", out_data, 6);
    new_hash_request = 1'b1;
    out_ready        = 1'b0;
    tick();
    new_hash_request = 1'b0;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_data0", out_data, 0);
    start_capture(1);
    check_eq("restart_valid", out_valid, 1);
    check_eq("restart_data", out_data, word_exp(1, 0));
    pulse_new_hash();

    // Second digest edge during word 3 sets overrun without disturbing the transfer
    out_ready = 1'b1;
    start_capture(1);
    for (int c = 0; c < 16; c++) begin
      check_eq("ovr_data", out_data, word_exp(1, c));
      if (c == 2) digest_valid = 1'b0;
      if (c == 3) begin
        check_eq("ovr_before", overrun, 0);
        digest_valid = 1'b1;
        digest       = make_digest(0);
      end
      if (c == 4) check_eq("ovr_set", overrun, 1);
      tick();
    end
    check_eq("ovr_end_valid", out_valid, 0);
    check_eq("ovr_sticky", overrun, 1);
    pulse_new_hash();
    check_eq("ovr_cleared", overrun, 0);

    // Edge coinciding with the final transfer
    start_capture(0);
    for (int c = 0; c < 16; c++) begin
      if (c == 14) digest_valid = 1'b0;
      if (c == 15) digest_valid = 1'b1;
      tick();
    end
    check_eq("fin_edge_valid", out_valid, 0);
    check_eq("fin_edge_ovr", overrun, 1);
    pulse_new_hash();
    check_eq("fin_edge_clr", overrun, 0);

    // new_hash_request beats a simultaneous capture edge
    digest_valid = 1'b0;
    tick();
    digest_valid     = 1'b1;
    new_hash_request = 1'b1;
    tick();
    check_eq("nhr_prio_valid", out_valid, 0);
    new_hash_request = 1'b0;
    tick();
    check_eq("nhr_prio_hold", out_valid, 0);

    // Asynchronous reset mid-transfer
    out_ready = 1'b1;
    start_capture(1);
    tick();
    tick();
    out_ready = 1'b0;
    check_eq("arst_pre_data", out_data, word_exp(1, 2));
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_data", out_data, 0);
    check_eq("arst_last", out_last, 0);
    check_eq("arst_busy", busy, 0);
    digest_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    tick();
    check_eq("arst_no_words", out_valid, 0);

    // digest_valid already high at reset release captures on the first clock
    reset_n      = 1'b0;
    digest       = make_digest(1);
    digest_valid = 1'b1;
    tick();
    #2 reset_n = 1'b1;
    tick();
    check_eq("rel_capture_valid", out_valid, 1);
    check_eq("rel_capture_data", out_data, word_exp(1, 0));
    pulse_new_hash();

`ifdef DIGEST_TRUNCATE_EN
    out_len   = 5'd4;
    out_ready = 1'b1;
    start_capture(1);
    for (int c = 0; c < 4; c++) begin
      check_eq("trunc_data", out_data, word_exp(1, c));
      check_eq("trunc_last", out_last, (c == 3));
      tick();
    end
    check_eq("trunc_end_valid", out_valid, 0);
    out_len = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
